if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage: PC generator and instruction ROM requester that produces the if_pc/if_inst pair consumed by the IF/ID pipeline register.
- Aligns the 1-cycle-latency synchronous ROM response with its own address, so the IF/ID register needs no delayed-PC copy.
- Handles the stall bus, branch redirect with a MIPS delay slot, and exception flush.
- Holds a returned instruction in a one-entry buffer while IF is stalled, so ROM data is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  stall bus; Stop=1. [0] holds PC, [1] holds IF, [2] holds ID.
- branch_flag_i  in  1  ID resolved a taken branch or jump.
- branch_target_i  in  32  branch destination.
- flush_i  in  1  exception/eret flush.
- new_pc_i  in  32  flush destination.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  32  ROM read address.
- rom_data  in  32  ROM data; valid 1 cycle after a rom_ce=1 request.
- if_pc  out  32  PC of the presented instruction; 0 when no valid instruction.
- if_inst  out  32  presented instruction; 0 (nop) when no valid instruction.

Behaviour:
State registers:
- pc: request address; rom_addr = pc.
- req_valid: a request issued last cycle returns data now.
- rsp_pc: address of that request.
- hold_valid, hold_pc, hold_inst: one-entry stall buffer.

Reset:
- pc=RESET_PC; rom_ce=0; req_valid=0; hold_valid=0; if_pc=0; if_inst=0.
- rom_ce rises the cycle after rst deasserts. The first valid if_inst appears 2 cycles after rst deasserts.

Output mux (combinational):
- hold_valid=1: present hold_pc/hold_inst.
- else req_valid=1: present rsp_pc/rom_data.
- else: present 0/0.

Issue rule:
- rom_ce=1 whenever not in reset.
- A request is issued in a cycle iff stall[0]=NoStop and stall[1]=NoStop.
- The next cycle's req_valid = issued and not squashed; rsp_pc = pc.

PC update, priority high to low:
1. rst.
2. flush_i: pc<=new_pc_i; req_valid<=0; hold_valid<=0. The stall bus is ignored this cycle.
3. branch_flag_i with stall[2]=NoStop: pc<=branch_target_i; the request issued this cycle is squashed (req_valid<=0). The instruction presented this cycle is the delay slot and is preserved: its hold entry, if any, is kept.
4. stall[0]=Stop or stall[1]=Stop: pc holds.
5. otherwise pc<=pc+PC_STEP, 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).

Hold buffer:
- Capture: stall[1]=Stop, hold_valid=0, req_valid=1 -> hold_pc<=rsp_pc, hold_inst<=rom_data, hold_valid<=1.
- Release: stall[1]=NoStop and hold_valid=1 -> hold_valid<=0. The buffered entry is presented that cycle and taken by IF/ID.
- Ordering: since no request is issued while stalled, the held entry is followed by the next sequential address, so order is preserved.

Boundary conditions:
- Branch arriving while stall[2]=Stop is ignored; ID re-presents it.
- Flush and branch in the same cycle: flush wins.
- Reset mid-stall clears the hold buffer.
- A stall starting and ending on consecutive cycles loses no instruction and duplicates none.

Decomposition:
- Shared defines header: `StallBus, Stop/NoStop, `InstAddrBus, `InstBus, `ZeroWord, RstEnable, ChipEnable/ChipDisable.
- Sub-module fetch_hold_buf: the one-entry buffer (capture/release/clear inputs; valid/pc/inst outputs).
- PC logic and issue logic stay in if_fetch.

Test Plan:
- Reset release, no stalls -> rom_addr 0,4,8,…; if_pc/if_inst = 0/0 for 2 cycles after release, then 0x0 with rom_data@0, then 0x4 with rom_data@4.
- stall=6'b000011 for 3 cycles while 0x8 is returned -> if_pc stays 0x8 with the same inst throughout; after release the sequence continues 0xC, 0x10 with no gap or duplicate.
- branch_flag_i=1, target 0x100, while 0x10 is presented -> 0x10 passes (delay slot); the request for 0x14 is squashed (one 0/0 cycle); then 0x100, 0x104.
- flush_i=1, new_pc_i=0x180, during an active stall with a held entry -> hold cleared; the next valid if_pc is 0x180.
- Branch while stall[2]=Stop -> pc unchanged; the redirect happens on the cycle stall[2] drops.
- PC at 0xFFFF_FFFC -> next rom_addr 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: stall bus encoding,
// address/instruction widths, chip-enable levels and the output source select.
package if_fetch_pkg;

  localparam int STALL_W  = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [31:0]        inst_addr_t;
  typedef logic [31:0]        inst_t;

  localparam logic       STOP         = 1'b1;
  localparam logic       NO_STOP      = 1'b0;
  localparam logic       RST_ENABLE   = 1'b1;
  localparam logic       CHIP_ENABLE  = 1'b1;
  localparam logic       CHIP_DISABLE = 1'b0;
  localparam inst_addr_t ZERO_WORD    = 32'h0000_0000;

  // Which state feeds the IF/ID pair this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RSP  = 2'd1,
    SRC_HOLD = 2'd2
  } fetch_src_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic inst_addr_t pc_advance(input inst_addr_t pc, input inst_addr_t step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: pipeline control in, ROM request/response, and the if_pc/if_inst pair out.
// master is the fetch stage; slave is the surrounding core and ROM.
interface if_fetch_if import if_fetch_pkg::*; ();

  stall_bus_t stall;
  logic       branch_flag_i;
  inst_addr_t branch_target_i;
  logic       flush_i;
  inst_addr_t new_pc_i;
  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_data;
  inst_addr_t if_pc;
  inst_t      if_inst;

  modport master (
    input  stall,
    input  branch_flag_i,
    input  branch_target_i,
    input  flush_i,
    input  new_pc_i,
    input  rom_data,
    output rom_ce,
    output rom_addr,
    output if_pc,
    output if_inst
  );

  modport slave (
    output stall,
    output branch_flag_i,
    output branch_target_i,
    output flush_i,
    output new_pc_i,
    output rom_data,
    input  rom_ce,
    input  rom_addr,
    input  if_pc,
    input  if_inst
  );

endinterface

// File: rtl/if_fetch_hold_buf.sv
// One-entry buffer that parks a returned ROM word while IF is stalled.
// Clear beats capture, capture beats release.
module fetch_hold_buf
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_capture,
  input  logic       i_release,
  input  logic       i_clear,
  input  inst_addr_t i_pc,
  input  inst_t      i_inst,
  output logic       o_valid,
  output inst_addr_t o_pc,
  output inst_t      o_inst
);

  logic       r_valid;
  inst_addr_t r_pc;
  inst_t      r_inst;

  // Entry state: reset/clear drop it, capture loads it, release consumes it.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_pc    <= ZERO_WORD;
      r_inst  <= ZERO_WORD;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_release) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, ROM request issue, response/address alignment,
// branch redirect with delay slot, flush, and the stall hold buffer.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter inst_addr_t PC_STEP  = 32'h0000_0004
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  inst_addr_t r_pc;
  inst_addr_t r_rsp_pc;
  logic       r_rom_ce;
  logic       r_req_valid;

  logic       w_stall_pc;
  logic       w_stall_if;
  logic       w_stall_id;
  logic       w_flush;
  logic       w_branch;
  logic       w_issue;
  inst_addr_t w_pc_next;
  logic       w_req_valid_next;

  logic       w_hold_capture;
  logic       w_hold_release;
  logic       w_hold_valid;
  inst_addr_t w_hold_pc;
  inst_t      w_hold_inst;

  fetch_src_t w_src;
  inst_addr_t w_if_pc;
  inst_t      w_if_inst;
  logic       w_unused;

  assign w_stall_pc = (bus.stall[STALL_PC] == STOP);
  assign w_stall_if = (bus.stall[STALL_IF] == STOP);
  assign w_stall_id = (bus.stall[STALL_ID] == STOP);
  assign w_unused   = &{1'b0, bus.stall[STALL_W-1:3]};

  // A branch seen while ID is stalled is re-presented by ID later, so ignore it now.
  assign w_flush  = bus.flush_i;
  assign w_branch = bus.branch_flag_i & ~w_stall_id;
  assign w_issue  = (r_rom_ce == CHIP_ENABLE) & ~w_stall_pc & ~w_stall_if;

  // Next PC and whether a response will be owed next cycle.
  always_comb begin
    w_pc_next        = r_pc;
    w_req_valid_next = 1'b0;
    if (w_flush) begin
      w_pc_next        = bus.new_pc_i;
      w_req_valid_next = 1'b0;
    end else if (w_branch) begin
      // The request issued this cycle is the fall-through after the delay slot: squash it.
      w_pc_next        = bus.branch_target_i;
      w_req_valid_next = 1'b0;
    end else if (w_issue) begin
      w_pc_next        = pc_advance(r_pc, PC_STEP);
      w_req_valid_next = 1'b1;
    end else begin
      w_pc_next        = r_pc;
      w_req_valid_next = 1'b0;
    end
  end

  // PC, chip enable and the in-flight request tag.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_pc        <= RESET_PC;
      r_rom_ce    <= CHIP_DISABLE;
      r_req_valid <= 1'b0;
      r_rsp_pc    <= ZERO_WORD;
    end else begin
      r_pc        <= w_pc_next;
      r_rom_ce    <= CHIP_ENABLE;
      r_req_valid <= w_req_valid_next;
      r_rsp_pc    <= r_pc;
    end
  end

  // Capture only an unbuffered live response; no request issues while stalled, so order holds.
  assign w_hold_capture = w_stall_if & ~w_hold_valid & r_req_valid;
  assign w_hold_release = ~w_stall_if & w_hold_valid;

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_hold_capture),
    .i_release (w_hold_release),
    .i_clear   (w_flush),
    .i_pc      (r_rsp_pc),
    .i_inst    (bus.rom_data),
    .o_valid   (w_hold_valid),
    .o_pc      (w_hold_pc),
    .o_inst    (w_hold_inst)
  );

  // Pick the presentation source: buffered entry first, then the live ROM response.
  always_comb begin
    w_src = SRC_NONE;
    if (w_hold_valid) begin
      w_src = SRC_HOLD;
    end else if (r_req_valid) begin
      w_src = SRC_RSP;
    end else begin
      w_src = SRC_NONE;
    end
  end

  // Drive the IF/ID pair; nop with PC 0 when nothing valid is available.
  always_comb begin
    w_if_pc   = ZERO_WORD;
    w_if_inst = ZERO_WORD;
    case (w_src)
      SRC_HOLD: begin
        w_if_pc   = w_hold_pc;
        w_if_inst = w_hold_inst;
      end
      SRC_RSP: begin
        w_if_pc   = r_rsp_pc;
        w_if_inst = bus.rom_data;
      end
      SRC_NONE: begin
        w_if_pc   = ZERO_WORD;
        w_if_inst = ZERO_WORD;
      end
      default: begin
        w_if_pc   = ZERO_WORD;
        w_if_inst = ZERO_WORD;
      end
    endcase
  end

  assign bus.rom_ce   = r_rom_ce;
  assign bus.rom_addr = r_pc;
  assign bus.if_pc    = w_if_pc;
  assign bus.if_inst  = w_if_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Directed table-driven bench for if_fetch with a 1-cycle synchronous ROM model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'h0000_0004)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  // Synchronous ROM: data for the address sampled at an enabled edge appears after it.
  initial bus.rom_data = 32'h0000_0000;
  always @(posedge clk) begin
    if (bus.rom_ce) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] npc;
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [5:0] st, input logic br, input logic [31:0] tgt,
                     input logic fl, input logic [31:0] npc, input logic ce, input logic [31:0] addr,
                     input logic v, input logic [31:0] pc);
    vec_t e;
    e.rst = r; e.stall = st; e.br = br; e.tgt = tgt; e.fl = fl; e.npc = npc;
    e.exp_ce = ce; e.exp_addr = addr; e.exp_v = v; e.exp_pc = pc;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive this cycle's inputs at the falling edge, then check state-driven outputs.
  task automatic apply(input int idx, input logic r, input logic [5:0] st, input logic br,
                       input logic [31:0] tgt, input logic fl, input logic [31:0] npc,
                       input logic ce, input logic [31:0] addr, input logic v, input logic [31:0] pc);
    logic [31:0] ce_w;
    logic [31:0] pc_exp;
    logic [31:0] inst_exp;
    @(negedge clk);
    rst = r;
    bus.stall = st;
    bus.branch_flag_i = br;
    bus.branch_target_i = tgt;
    bus.flush_i = fl;
    bus.new_pc_i = npc;
    #1;
    ce_w     = {31'd0, bus.rom_ce};
    pc_exp   = v ? pc : 32'h0000_0000;
    inst_exp = v ? rom_fn(pc) : 32'h0000_0000;
    check("rom_ce", idx, ce_w, {31'd0, ce});
    check("rom_addr", idx, bus.rom_addr, addr);
    check("if_pc", idx, bus.if_pc, pc_exp);
    check("if_inst", idx, bus.if_inst, inst_exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.stall = 6'b000000;
    bus.branch_flag_i = 1'b0;
    bus.branch_target_i = 32'h0000_0000;
    bus.flush_i = 1'b0;
    bus.new_pc_i = 32'h0000_0000;
    repeat (2) @(posedge clk);

    //   rst   stall       br    tgt           fl    npc           ce    addr          v     pc
    add(1'b1, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
    // three-cycle stall while 0x8 is returned, then release
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C);
    // branch to 0x100 while 0x10 (delay slot) is presented
    add(1'b0, 6'b000000, 1'b1, 32'h100,      1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);
    // branch while ID is stalled is ignored until stall[2] drops
    add(1'b0, 6'b000111, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b0, 6'b000111, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b0, 6'b000000, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b0, 32'h0);
    // flush to 0x180 during a stall holding 0x200
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b1, 32'h180,      1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0180, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0180, 1'b0, 32'h0);
    // flush and branch together: flush wins, landing on the wrap point
    add(1'b0, 6'b000000, 1'b1, 32'h300,      1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0184, 1'b1, 32'h0000_0180);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
    // single-cycle stall
    add(1'b0, 6'b000011, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
    // PC-only stall: IF consumes 0x8, no capture, one bubble
    add(1'b0, 6'b000001, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0);
    add(1'b0, 6'b000000, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C);

    foreach (vq[i]) begin
      apply(i, vq[i].rst, vq[i].stall, vq[i].br, vq[i].tgt, vq[i].fl, vq[i].npc,
            vq[i].exp_ce, vq[i].exp_addr, vq[i].exp_v, vq[i].exp_pc);
    end

    // Reset arriving mid-stall with a held entry must clear the buffer.
    apply(100, 1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010);
    apply(101, 1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010);
    apply(102, 1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0);
    apply(103, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
    apply(104, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
    apply(105, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
